// File: rtl/adder4_pkg.sv
// adder4_pkg
//   Shared definitions for the 4-bit adder sweep controller:
//   - ADDER4_WIDTH : default operand width of the adder under test
//   - stateT       : sweep FSM state type with IDLE/SETTLE/CHECK/DONE codes
//   - add_ref      : golden {cout,sum} of a+b+cin, ADDER4_WIDTH+1 bits
package adder4_pkg;

  localparam int ADDER4_WIDTH = 4;

  typedef logic [1:0] stateT;

  localparam stateT IDLE   = 2'd0;
  localparam stateT SETTLE = 2'd1;
  localparam stateT CHECK  = 2'd2;
  localparam stateT DONE   = 2'd3;

  function automatic logic [ADDER4_WIDTH:0] add_ref(
    input logic [ADDER4_WIDTH-1:0] a,
    input logic [ADDER4_WIDTH-1:0] b,
    input logic                    cin
  );
    return {1'b0, a} + {1'b0, b} + {{ADDER4_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder4_operand_gen.sv
// adder4_operand_gen
//   Nested operand counter for the adder sweep: opB is the fastest digit,
//   opA the next, opCin the slowest (only swept when SWEEP_CIN=1).
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (operands to 0)
//   clear    in   reload operands to 0 at the start of a sweep
//   advance  in   step to the next vector (ignored on the last vector)
//   opA      out  adder inA, registered
//   opB      out  adder inB, registered
//   opCin    out  adder Cin, registered
//   lastVec  out  current operands are the final vector of the sweep
module adder4_operand_gen #(
  parameter int WIDTH     = 4,
  parameter int SWEEP_CIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic             opCin,
  output logic             lastVec
);

  localparam logic [WIDTH-1:0] OP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Without a Cin sweep the final vector is reached with Cin still at 0.
  always_comb begin
    lastVec = (&opA) && (&opB) && ((SWEEP_CIN != 0) ? opCin : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      opA   <= '0;
      opB   <= '0;
      opCin <= 1'b0;
    end else if (advance && !lastVec) begin
      opB <= opB + OP_ONE;
      if (&opB) begin
        opA <= opA + OP_ONE;
        // Wrap of opA can only happen with Cin=0 here, since {1,F,F} is last.
        if ((&opA) && (SWEEP_CIN != 0)) begin
          opCin <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder4_sweep_ctrl.sv
// adder4_sweep_ctrl
//   Self-checking exhaustive sweep of a 4-bit ripple-carry adder. Drives
//   operands, waits SETTLE_CYCLES, samples {coutIn,sumIn}, compares against
//   the golden sum, counts mismatches and optionally records the first one.
//   Optional feature macro: ADDER4_FIRST_ERR_CAPTURE_EN
//     defined   -> first_err_valid/first_err_vec capture the first mismatch
//     undefined -> first_err_valid/first_err_vec are tied to 0
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   synchronous active-low reset
//   start            in   one-cycle sweep request (ignored while busy)
//   busy             out  sweep in progress
//   done             out  sweep finished, results held
//   opA/opB/opCin    out  registered adder operands
//   sumIn/coutIn     in   adder result, sampled only in CHECK
//   err_count        out  saturating mismatch count
//   first_err_valid  out  a mismatch has been captured
//   first_err_vec    out  {cin,a,b} of the first mismatch
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | operands held while the adder settles
// CHECK  | sample and compare result, advance operands
// DONE   | sweep complete, results held until next start
module adder4_sweep_ctrl
  import adder4_pkg::*;
#(
  parameter int WIDTH         = ADDER4_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int SWEEP_CIN     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   opA,
  output logic [WIDTH-1:0]   opB,
  output logic               opCin,
  input  logic [WIDTH-1:0]   sumIn,
  input  logic               coutIn,
  output logic [2*WIDTH+1:0] err_count,
  output logic               first_err_valid,
  output logic [2*WIDTH:0]   first_err_vec
);

  localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2*WIDTH+1:0] ERR_ONE     = {{(2*WIDTH+1){1'b0}}, 1'b1};

  stateT          state;
  logic [3:0]     settleCnt;
  logic [WIDTH:0] expected;
  logic           mismatch;
  logic           clearRes;
  logic           advance;
  logic           lastVec;

  always_comb begin
    expected = add_ref(opA, opB, opCin);
    mismatch = (state == CHECK) && ({coutIn, sumIn} != expected);
    // A start is only honoured when no sweep is running.
    clearRes = start && ((state == IDLE) || (state == DONE));
    advance  = (state == CHECK);
  end

  adder4_operand_gen #(
    .WIDTH    (WIDTH),
    .SWEEP_CIN(SWEEP_CIN)
  ) uOperandGen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clearRes),
    .advance(advance),
    .opA    (opA),
    .opB    (opB),
    .opCin  (opCin),
    .lastVec(lastVec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      settleCnt <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SETTLE;
            settleCnt <= 4'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
          end
        end
        SETTLE: begin
          if (settleCnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settleCnt <= settleCnt + 4'd1;
          end
        end
        CHECK: begin
          if (mismatch && !(&err_count)) begin
            err_count <= err_count + ERR_ONE;
          end
          if (lastVec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= SETTLE;
            settleCnt <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER4_FIRST_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clearRes) begin
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_vec   <= {opCin, opA, opB};
    end
  end
`else
  assign first_err_valid = 1'b0;
  assign first_err_vec   = '0;
`endif

endmodule

// File: tb/tb_adder4_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_adder4_sweep_ctrl;

  localparam int W = 4;
`ifdef ADDER4_FIRST_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  bit   stuck0 = 1'b0;

  logic busy0, done0, opCin0, fv0, busy1, done1, opCin1, fv1;
  logic [W-1:0] opA0, opB0, sum0, opA1, opB1, sum1;
  logic cout0, cout1;
  logic [2*W+1:0] err0, err1;
  logic [2*W:0] fvec0, fvec1;
  logic [W:0] raw0, raw1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Adder models: dut0 may have sum bit0 stuck at 0, dut1 is always correct.
  assign raw0 = {1'b0, opA0} + {1'b0, opB0} + {{W{1'b0}}, opCin0};
  assign sum0 = raw0[W-1:0] & (stuck0 ? 4'b1110 : 4'b1111);
  assign cout0 = raw0[W];
  assign raw1 = {1'b0, opA1} + {1'b0, opB1} + {{W{1'b0}}, opCin1};
  assign sum1 = raw1[W-1:0];
  assign cout1 = raw1[W];

  adder4_sweep_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .opA(opA0), .opB(opB0), .opCin(opCin0), .sumIn(sum0), .coutIn(cout0),
    .err_count(err0), .first_err_valid(fv0), .first_err_vec(fvec0));

  adder4_sweep_ctrl #(.SETTLE_CYCLES(1), .SWEEP_CIN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .opA(opA1), .opB(opB1), .opCin(opCin1), .sumIn(sum1), .coutIn(cout1),
    .err_count(err1), .first_err_valid(fv1), .first_err_vec(fvec1));

  // Packed view: {busy,done,cin,a,b,err_count,first_err_valid,first_err_vec}
  logic [30:0] obs [2];
  assign obs[0] = {busy0, done0, opCin0, opA0, opB0, err0, fv0, fvec0};
  assign obs[1] = {busy1, done1, opCin1, opA1, opB1, err1, fv1, fvec1};

  // Behavioural model: position in the sweep as a cycle count since start.
  int settle[2]   = '{2, 1};
  bit sweepCin[2] = '{1'b1, 1'b0};
  bit running[2]  = '{1'b0, 1'b0};
  bit doneM[2]    = '{1'b0, 1'b0};
  int t[2]        = '{0, 0};
  int errM[2]     = '{0, 0};
  bit fvM[2]      = '{1'b0, 1'b0};
  int fvecM[2]    = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelStep(input int i, input bit st, input bit flt);
    int per, nv, v, a, b, c;
    per = settle[i] + 1;
    nv  = sweepCin[i] ? 512 : 256;
    if (!rst_n) begin
      running[i] = 0; doneM[i] = 0; t[i] = 0; errM[i] = 0; fvM[i] = 0; fvecM[i] = 0;
    end else if (running[i]) begin
      t[i]++;
      if (t[i] % per == 0) begin
        v = t[i] / per - 1;
        c = v / 256; a = (v / 16) % 16; b = v % 16;
        if (flt && ((a + b + c) % 2 == 1)) begin
          if (errM[i] < 1023) errM[i]++;
          if (CAP && !fvM[i]) begin fvM[i] = 1; fvecM[i] = v; end
        end
        if (t[i] == nv * per) begin running[i] = 0; doneM[i] = 1; end
      end
    end else if (st) begin
      running[i] = 1; t[i] = 0; doneM[i] = 0; errM[i] = 0; fvM[i] = 0; fvecM[i] = 0;
    end
  endtask

  function automatic logic [31:0] expectPack(input int i);
    int v;
    if (running[i]) v = t[i] / (settle[i] + 1);
    else if (doneM[i]) v = (sweepCin[i] ? 512 : 256) - 1;
    else v = 0;
    return {1'b0, running[i], doneM[i], 9'(v), 10'(errM[i]), fvM[i], 9'(fvecM[i])};
  endfunction

  initial forever begin
    @(posedge clk);
    modelStep(0, start0, stuck0);
    modelStep(1, start1, 1'b0);
  end

  initial forever begin
    @(negedge clk);
    check("cycle_dut0", {1'b0, obs[0]}, expectPack(0));
    check("cycle_dut1", {1'b0, obs[1]}, expectPack(1));
  end

  task automatic setStart(input int i, input logic v);
    if (i == 0) start0 = v; else start1 = v;
  endtask

  task automatic runSweep(input int i, input bit pulseMid, output int busyCycles, output bit cinSeen);
    int n;
    busyCycles = 0; cinSeen = 0; n = 0;
    @(negedge clk); setStart(i, 1'b1);
    @(negedge clk); setStart(i, 1'b0);
    check("restart_clear", {22'd0, obs[i][29], obs[i][19:10]}, 32'd0);
    while (obs[i][29] !== 1'b1 && n < 4000) begin
      if (obs[i][30] === 1'b1) busyCycles++;
      if (obs[i][28] === 1'b1) cinSeen = 1;
      setStart(i, (pulseMid && (n == 10 || n == 11)) ? 1'b1 : 1'b0);
      @(negedge clk);
      n++;
    end
    setStart(i, 1'b0);
    check("sweep_done", {31'd0, obs[i][29]}, 32'd1);
  endtask

  initial begin
    int bc;
    bit cs;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dut0", {1'b0, obs[0]}, 32'd0);
    check("reset_dut1", {1'b0, obs[1]}, 32'd0);
    rst_n = 1'b1;

    // Correct adder, default parameters.
    runSweep(0, 1'b0, bc, cs);
    check("busy_cycles_ok", bc, 32'd1536);
    check("err_ok", {22'd0, err0}, 32'd0);
    check("fv_ok", {31'd0, fv0}, 32'd0);
    check("final_ops", {23'd0, opCin0, opA0, opB0}, 32'h1FF);

    // Sum bit0 stuck at 0.
    stuck0 = 1'b1;
    runSweep(0, 1'b0, bc, cs);
    check("busy_cycles_stuck", bc, 32'd1536);
    check("err_stuck", {22'd0, err0}, 32'd256);
    check("fv_stuck", {31'd0, fv0}, CAP ? 32'd1 : 32'd0);
    check("fvec_stuck", {23'd0, fvec0}, CAP ? 32'h001 : 32'h000);

    // Restart from DONE with the adder fixed.
    stuck0 = 1'b0;
    runSweep(0, 1'b0, bc, cs);
    check("busy_cycles_restart", bc, 32'd1536);
    check("err_restart", {22'd0, err0}, 32'd0);

    // No Cin sweep, one settle cycle.
    runSweep(1, 1'b0, bc, cs);
    check("busy_cycles_nocin", bc, 32'd512);
    check("cin_never_1", {31'd0, cs}, 32'd0);
    check("err_nocin", {22'd0, err1}, 32'd0);
    check("final_ops_nocin", {23'd0, opCin1, opA1, opB1}, 32'h0FF);

    // Reset for one cycle at cycle 700 of a sweep.
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (699) @(negedge clk);
    check("busy_before_rst", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_reset_dut0", {1'b0, obs[0]}, 32'd0);
    check("mid_reset_dut1", {1'b0, obs[1]}, 32'd0);
    runSweep(0, 1'b0, bc, cs);
    check("busy_cycles_after_rst", bc, 32'd1536);
    check("err_after_rst", {22'd0, err0}, 32'd0);

    // start pulsed during SETTLE and CHECK.
    runSweep(0, 1'b1, bc, cs);
    check("busy_cycles_ignored_start", bc, 32'd1536);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
